// File: rtl/ht_res_buffer.sv
// ht_res_buffer: first-word-fall-through result buffer behind the engine result mux.
// Results enter over a valid/ready handshake. They leave from registered head-of-queue outputs.
// Optional per-opcode ok/fail statistics are built only when HT_RES_BUF_STAT_EN is defined.
// Without that macro the counter outputs are tied to zero and stat_clear_i is ignored.
module ht_res_buffer #(
    parameter int unsigned RES_W     = 64,
    parameter int unsigned DEPTH     = 8,
    parameter int unsigned CNT_W     = 32,
    parameter logic [7:0]  FAIL_MASK = 8'hF0
) (
    input  logic                     clk_i,
    input  logic                     rst_i,
    input  logic [RES_W-1:0]         res_data_i,
    input  logic [1:0]               res_cmd_i,
    input  logic [2:0]               res_rescode_i,
    input  logic                     res_valid_i,
    output logic                     res_ready_o,
    output logic [RES_W-1:0]         res_data_o,
    output logic [1:0]               res_cmd_o,
    output logic [2:0]               res_rescode_o,
    output logic                     res_valid_o,
    input  logic                     res_ready_i,
    output logic [$clog2(DEPTH):0]   used_words_o,
    input  logic                     stat_clear_i,
    output logic [4*CNT_W-1:0]       stat_ok_cnt_o,
    output logic [4*CNT_W-1:0]       stat_fail_cnt_o
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned OCC_W = PTR_W + 1;

    logic [RES_W-1:0] r_mem_data [DEPTH];
    logic [1:0]       r_mem_cmd  [DEPTH];
    logic [2:0]       r_mem_rc   [DEPTH];

    logic [PTR_W-1:0] r_wr_ptr;
    logic [PTR_W-1:0] r_rd_ptr;
    logic [PTR_W-1:0] w_rd_next;
    logic [OCC_W-1:0] r_count;
    logic [OCC_W-1:0] w_count_next;
    logic             w_accept;
    logic             w_pop;
    logic             w_bypass;

    assign res_ready_o  = (r_count != OCC_W'(DEPTH));
    assign used_words_o = r_count;
    assign w_accept     = res_valid_i & res_ready_o;
    assign w_pop        = res_valid_o & res_ready_i;
    assign w_rd_next    = r_rd_ptr + PTR_W'(w_pop);
    assign w_count_next = r_count + OCC_W'(w_accept) - OCC_W'(w_pop);
    // The incoming entry becomes head when the queue is empty after this cycle's pop.
    assign w_bypass     = w_accept & (r_wr_ptr == w_rd_next);

    // Storage write; contents are intentionally not reset.
    always_ff @(posedge clk_i) begin
        if (w_accept) begin
            r_mem_data[r_wr_ptr] <= res_data_i;
            r_mem_cmd[r_wr_ptr]  <= res_cmd_i;
            r_mem_rc[r_wr_ptr]   <= res_rescode_i;
        end
    end

    // Pointers and occupancy.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_accept) begin
                r_wr_ptr <= r_wr_ptr + PTR_W'(1);
            end
            r_rd_ptr <= w_rd_next;
            r_count  <= w_count_next;
        end
    end

    // Registered head: bypass from input when the queue is empty, otherwise read the next entry.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            res_valid_o   <= 1'b0;
            res_data_o    <= '0;
            res_cmd_o     <= '0;
            res_rescode_o <= '0;
        end else begin
            res_valid_o <= (w_count_next != '0);
            if (w_bypass) begin
                res_data_o    <= res_data_i;
                res_cmd_o     <= res_cmd_i;
                res_rescode_o <= res_rescode_i;
            end else if (w_count_next != '0) begin
                res_data_o    <= r_mem_data[w_rd_next];
                res_cmd_o     <= r_mem_cmd[w_rd_next];
                res_rescode_o <= r_mem_rc[w_rd_next];
            end
        end
    end

`ifdef HT_RES_BUF_STAT_EN
    logic [CNT_W-1:0] r_ok_cnt   [4];
    logic [CNT_W-1:0] r_fail_cnt [4];
    logic [3:0]       w_ok_hit;
    logic [3:0]       w_fail_hit;
    logic             w_is_fail;

    assign w_is_fail = FAIL_MASK[res_rescode_i];

    // Decode which counter, if any, this cycle's accept targets.
    always_comb begin
        w_ok_hit   = '0;
        w_fail_hit = '0;
        for (int i = 0; i < 4; i++) begin
            w_ok_hit[i]   = w_accept & ~w_is_fail & (res_cmd_i == 2'(i));
            w_fail_hit[i] = w_accept &  w_is_fail & (res_cmd_i == 2'(i));
        end
    end

    // Saturating counters; a clear coinciding with an accept leaves that counter at 1.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            for (int i = 0; i < 4; i++) begin
                r_ok_cnt[i]   <= '0;
                r_fail_cnt[i] <= '0;
            end
        end else begin
            for (int i = 0; i < 4; i++) begin
                if (stat_clear_i) begin
                    r_ok_cnt[i]   <= CNT_W'(w_ok_hit[i]);
                    r_fail_cnt[i] <= CNT_W'(w_fail_hit[i]);
                end else begin
                    if (w_ok_hit[i] && (r_ok_cnt[i] != '1)) begin
                        r_ok_cnt[i] <= r_ok_cnt[i] + CNT_W'(1);
                    end
                    if (w_fail_hit[i] && (r_fail_cnt[i] != '1)) begin
                        r_fail_cnt[i] <= r_fail_cnt[i] + CNT_W'(1);
                    end
                end
            end
        end
    end

    for (genvar g = 0; g < 4; g++) begin : g_stat_pack
        assign stat_ok_cnt_o[g*CNT_W +: CNT_W]   = r_ok_cnt[g];
        assign stat_fail_cnt_o[g*CNT_W +: CNT_W] = r_fail_cnt[g];
    end
`else
    logic w_unused_stat;

    assign stat_ok_cnt_o   = '0;
    assign stat_fail_cnt_o = '0;
    assign w_unused_stat   = stat_clear_i ^ (|FAIL_MASK);
`endif

endmodule

// File: tb/tb_ht_res_buffer.sv
// Self-checking bench for ht_res_buffer.
// A queue model and per-opcode counters are compared against the DUT on every falling edge.
// Directed scenarios pin the model with literal values, and a randomized phase follows.
`timescale 1ns/1ps
module tb_ht_res_buffer;

    localparam int unsigned RES_W = 64;
    localparam int unsigned DEPTH = 8;
    localparam int unsigned CNT_W = 4;
    localparam int unsigned OCC_W = $clog2(DEPTH) + 1;
    localparam int          SAT   = (1 << CNT_W) - 1;
`ifdef HT_RES_BUF_STAT_EN
    localparam bit STAT = 1'b1;
`else
    localparam bit STAT = 1'b0;
`endif

    logic                 clk_i;
    logic                 rst_i;
    logic [RES_W-1:0]     res_data_i;
    logic [1:0]           res_cmd_i;
    logic [2:0]           res_rescode_i;
    logic                 res_valid_i;
    logic                 res_ready_o;
    logic [RES_W-1:0]     res_data_o;
    logic [1:0]           res_cmd_o;
    logic [2:0]           res_rescode_o;
    logic                 res_valid_o;
    logic                 res_ready_i;
    logic [OCC_W-1:0]     used_words_o;
    logic                 stat_clear_i;
    logic [4*CNT_W-1:0]   stat_ok_cnt_o;
    logic [4*CNT_W-1:0]   stat_fail_cnt_o;

    ht_res_buffer #(
        .RES_W     (RES_W),
        .DEPTH     (DEPTH),
        .CNT_W     (CNT_W),
        .FAIL_MASK (8'hF0)
    ) dut (
        .clk_i           (clk_i),
        .rst_i           (rst_i),
        .res_data_i      (res_data_i),
        .res_cmd_i       (res_cmd_i),
        .res_rescode_i   (res_rescode_i),
        .res_valid_i     (res_valid_i),
        .res_ready_o     (res_ready_o),
        .res_data_o      (res_data_o),
        .res_cmd_o       (res_cmd_o),
        .res_rescode_o   (res_rescode_o),
        .res_valid_o     (res_valid_o),
        .res_ready_i     (res_ready_i),
        .used_words_o    (used_words_o),
        .stat_clear_i    (stat_clear_i),
        .stat_ok_cnt_o   (stat_ok_cnt_o),
        .stat_fail_cnt_o (stat_fail_cnt_o)
    );

    initial clk_i = 1'b0;
    always #5 clk_i = ~clk_i;

    typedef struct {
        logic [RES_W-1:0] d;
        logic [1:0]       c;
        logic [2:0]       r;
    } ent_t;

    ent_t       mq[$];
    int         m_ok[4];
    int         m_fail[4];
    logic [7:0] fmask = 8'hF0;
    int         n_tests = 0;
    int         n_fail  = 0;
    bit         last_acc = 1'b0;

    function automatic void chk(string name, logic [63:0] act, logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endfunction

    function automatic logic [63:0] dut_ok(int op);
        return 64'(stat_ok_cnt_o[op*CNT_W +: CNT_W]);
    endfunction

    function automatic logic [63:0] dut_fail(int op);
        return 64'(stat_fail_cnt_o[op*CNT_W +: CNT_W]);
    endfunction

    function automatic logic [63:0] exp_stat(int v);
        return STAT ? 64'(v) : 64'(0);
    endfunction

    function automatic void model_clear_stats();
        for (int i = 0; i < 4; i++) begin
            m_ok[i]   = 0;
            m_fail[i] = 0;
        end
    endfunction

    // Compare DUT against the model away from the active edge.
    always @(negedge clk_i) begin
        chk("valid", 64'(res_valid_o), 64'(mq.size() != 0));
        chk("ready", 64'(res_ready_o), 64'(mq.size() != DEPTH));
        chk("used",  64'(used_words_o), 64'(mq.size()));
        if (mq.size() != 0) begin
            chk("head_data", 64'(res_data_o),    64'(mq[0].d));
            chk("head_cmd",  64'(res_cmd_o),     64'(mq[0].c));
            chk("head_rc",   64'(res_rescode_o), 64'(mq[0].r));
        end
        for (int op = 0; op < 4; op++) begin
            chk("ok_cnt",   dut_ok(op),   exp_stat(m_ok[op]));
            chk("fail_cnt", dut_fail(op), exp_stat(m_fail[op]));
        end
    end

    // One clock: the model applies this cycle's handshakes, then inputs may change at +1.
    task automatic step();
        bit   acc;
        bit   pop;
        ent_t e;
        @(posedge clk_i);
        acc = 1'b0;
        if (rst_i) begin
            acc = res_valid_i && (mq.size() != DEPTH);
            pop = res_ready_i && (mq.size() != 0);
            if (stat_clear_i) model_clear_stats();
            if (acc) begin
                if (fmask[res_rescode_i]) begin
                    if (m_fail[res_cmd_i] < SAT) m_fail[res_cmd_i]++;
                end else begin
                    if (m_ok[res_cmd_i] < SAT) m_ok[res_cmd_i]++;
                end
            end
            if (pop) void'(mq.pop_front());
            if (acc) begin
                e.d = res_data_i;
                e.c = res_cmd_i;
                e.r = res_rescode_i;
                mq.push_back(e);
            end
        end
        last_acc = acc;
        #1;
    endtask

    task automatic drive(bit v, logic [RES_W-1:0] d, logic [1:0] c, logic [2:0] r);
        res_valid_i   = v;
        res_data_i    = d;
        res_cmd_i     = c;
        res_rescode_i = r;
    endtask

    // Present one result and hold it until accepted, bounded.
    task automatic push(logic [RES_W-1:0] d, logic [1:0] c, logic [2:0] r);
        drive(1'b1, d, c, r);
        for (int k = 0; k < 64; k++) begin
            step();
            if (last_acc) break;
        end
        chk("push_accepted", 64'(last_acc), 64'(1));
    endtask

    task automatic drain();
        drive(1'b0, '0, 2'd0, 3'd0);
        res_ready_i = 1'b1;
        for (int k = 0; k < 64; k++) begin
            if (mq.size() == 0) break;
            step();
        end
        chk("drain_empty", 64'(mq.size()), 64'(0));
    endtask

    task automatic assert_reset();
        rst_i = 1'b0;
        mq.delete();
        model_clear_stats();
        #1;
        chk("rst_valid", 64'(res_valid_o),   64'(0));
        chk("rst_ready", 64'(res_ready_o),   64'(1));
        chk("rst_used",  64'(used_words_o),  64'(0));
        chk("rst_data",  64'(res_data_o),    64'(0));
        chk("rst_cmd",   64'(res_cmd_o),     64'(0));
        chk("rst_rc",    64'(res_rescode_o), 64'(0));
        chk("rst_ok3",   dut_ok(3),          64'(0));
    endtask

    initial begin
        bit pend;
        int thr;
        rst_i        = 1'b1;
        res_ready_i  = 1'b0;
        stat_clear_i = 1'b0;
        drive(1'b0, '0, 2'd0, 3'd0);
        model_clear_stats();
        #2;
        assert_reset();
        @(posedge clk_i);
        #1 rst_i = 1'b1;

        // Single SEARCH result flows through with one cycle of latency.
        res_ready_i = 1'b1;
        push(64'h1234, 2'd1, 3'd0);
        drive(1'b0, '0, 2'd0, 3'd0);
        chk("t1_valid", 64'(res_valid_o), 64'(1));
        chk("t1_data",  64'(res_data_o),  64'h1234);
        chk("t1_cmd",   64'(res_cmd_o),   64'(1));
        chk("t1_ok1",   dut_ok(1),        exp_stat(1));
        step();
        chk("t1_used",  64'(used_words_o), 64'(0));
        chk("t1_empty", 64'(res_valid_o),  64'(0));

        // Fill to DEPTH with the consumer stalled, then drain ten in order.
        res_ready_i = 1'b0;
        for (int i = 0; i < 8; i++) push(64'(100 + i), 2'(i), 3'(i));
        chk("t2_used8",  64'(used_words_o), 64'(8));
        chk("t2_full",   64'(res_ready_o),  64'(0));
        chk("t2_head",   64'(res_data_o),   64'(100));
        drive(1'b1, 64'(108), 2'd1, 3'd0);
        step();
        step();
        chk("t2_held",   64'(last_acc),     64'(0));
        chk("t2_still8", 64'(used_words_o), 64'(8));
        res_ready_i = 1'b1;
        push(64'(108), 2'd1, 3'd0);
        push(64'(109), 2'd2, 3'd1);
        drain();

        // Occupancy one with push and pop every cycle across pointer wrap.
        res_ready_i = 1'b0;
        push(64'(500), 2'd2, 3'd0);
        res_ready_i = 1'b1;
        for (int k = 0; k < 20; k++) begin
            drive(1'b1, 64'(600 + k), 2'd2, 3'd0);
            step();
            chk("t3_acc",  64'(last_acc),     64'(1));
            chk("t3_used", 64'(used_words_o), 64'(1));
        end
        chk("t3_head", 64'(res_data_o), 64'(619));
        drain();

        // INSERT failures versus successes.
        stat_clear_i = 1'b1;
        step();
        stat_clear_i = 1'b0;
        for (int k = 0; k < 3; k++) push(64'(700 + k), 2'd2, 3'd4);
        for (int k = 0; k < 2; k++) push(64'(710 + k), 2'd2, 3'd2);
        drain();
        chk("t4_fail2", dut_fail(2), exp_stat(3));
        chk("t4_ok2",   dut_ok(2),   exp_stat(2));
        chk("t4_ok1",   dut_ok(1),   64'(0));
        chk("t4_fail3", dut_fail(3), 64'(0));

        // Saturation at 2^CNT_W-1, then clear coinciding with an accept.
        for (int k = 0; k < 20; k++) push(64'(800 + k), 2'd3, 3'd0);
        drain();
        chk("t5_sat", dut_ok(3), exp_stat(15));
        drive(1'b1, 64'(900), 2'd3, 3'd1);
        stat_clear_i = 1'b1;
        step();
        stat_clear_i = 1'b0;
        drive(1'b0, '0, 2'd0, 3'd0);
        chk("t5_clr_acc", 64'(last_acc), 64'(1));
        chk("t5_clr_ok3", dut_ok(3),     exp_stat(1));
        chk("t5_clr_ok2", dut_ok(2),     64'(0));
        drain();

        // Reset with five entries buffered, then a normal push.
        res_ready_i = 1'b0;
        for (int k = 0; k < 5; k++) push(64'(1000 + k), 2'd0, 3'd0);
        chk("t6_used5", 64'(used_words_o), 64'(5));
        assert_reset();
        step();
        rst_i = 1'b1;
        drive(1'b0, '0, 2'd0, 3'd0);
        step();
        chk("t6_after_used", 64'(used_words_o), 64'(0));
        res_ready_i = 1'b1;
        push(64'(777), 2'd1, 3'd5);
        drive(1'b0, '0, 2'd0, 3'd0);
        chk("t6_valid", 64'(res_valid_o), 64'(1));
        chk("t6_data",  64'(res_data_o),  64'(777));
        chk("t6_fail1", dut_fail(1),      exp_stat(1));
        drain();

        // Randomized traffic with holding upstream and varying consumer pressure.
        pend = 1'b0;
        thr  = 50;
        for (int n = 0; n < 3000; n++) begin
            if ((n % 500) == 0) thr = int'($urandom_range(10, 90));
            if (!pend) begin
                if ($urandom_range(0, 99) < 60) begin
                    pend = 1'b1;
                    drive(1'b1, {$urandom, $urandom}, 2'($urandom_range(0, 3)),
                          3'($urandom_range(0, 7)));
                end else begin
                    res_valid_i = 1'b0;
                end
            end
            res_ready_i  = (int'($urandom_range(0, 99)) < thr);
            stat_clear_i = ($urandom_range(0, 199) == 0);
            step();
            if (last_acc) pend = 1'b0;
        end
        stat_clear_i = 1'b0;
        drain();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/ht_res_buffer.md
Name: ht_res_buffer

Overview:
Stage directly downstream of the data table engine result mux. It accepts each completed command result (search/insert/delete/init) over a valid/ready handshake and buffers it in a first-word-fall-through FIFO so a slow result consumer never stalls the engines beyond FIFO depth. Its optional per-command statistics block counts accepted results and failure rescodes for host readout.

Parameters:
RES_W, 64, width of opaque result payload (key/value/bucket fields, packed).
DEPTH, 8, FIFO entries; power of 2, >= 2.
CNT_W, 32, width of each statistics counter.
FAIL_MASK, 8'hF0, bit r set = rescode r counts as a failure.

Ports:
clk_i  in  1  clock.
rst_i  in  1  asynchronous reset, active low.
res_data_i  in  RES_W  result payload from engine result mux.
res_cmd_i  in  2  opcode: 0 INIT, 1 SEARCH, 2 INSERT, 3 DELETE.
res_rescode_i  in  3  result code.
res_valid_i  in  1  input result valid.
res_ready_o  out  1  buffer can accept.
res_data_o  out  RES_W  head-of-FIFO payload.
res_cmd_o  out  2  head-of-FIFO opcode.
res_rescode_o  out  3  head-of-FIFO rescode.
res_valid_o  out  1  head-of-FIFO valid.
res_ready_i  in  1  downstream consumer ready.
used_words_o  out  $clog2(DEPTH)+1  current occupancy.
stat_clear_i  in  1  synchronous clear of all statistics counters.
stat_ok_cnt_o  out  4*CNT_W  per-opcode non-failure count; slice [op*CNT_W +: CNT_W].
stat_fail_cnt_o  out  4*CNT_W  per-opcode failure count, same slicing.

Behaviour:
- Reset (rst_i low, async): FIFO pointers 0, used_words_o=0, res_valid_o=0, res_ready_o=1, all counters 0, res_data_o/cmd/rescode=0.
- Input accept = res_valid_i & res_ready_o. Output pop = res_valid_o & res_ready_i.
- res_ready_o = (used_words_o != DEPTH), combinational from registered occupancy. Accept when full is impossible. Input handshake rule: res_valid_i must stay high with stable fields until accepted.
- Output fields are registers. Latency: a result accepted into an empty FIFO appears with res_valid_o=1 on the next cycle.
- res_valid_o stays high with stable fields until popped.
- Simultaneous accept and pop: occupancy unchanged. When occupancy is 1, the new entry becomes head the cycle after the pop, with no bubble beyond one cycle. When occupancy >1, order is preserved.
- Pointers are $clog2(DEPTH) bits and wrap modulo DEPTH. Occupancy uses one extra bit so full (DEPTH) and empty (0) are distinct.
- FIFO storage is flops or RAM with registered head output. Storage is not reset; only pointers and valid are reset.
- Statistics: on each accept, if FAIL_MASK[res_rescode_i] then increment stat_fail_cnt[res_cmd_i], else increment stat_ok_cnt[res_cmd_i].
- Counters saturate at 2^CNT_W-1 and do not wrap.
- stat_clear_i zeroes all counters. If clear and accept occur in the same cycle, the counter for that accept ends at 1 and all others end at 0.
- Reset mid-transfer: any held or buffered results are discarded. The consumer must ignore res_valid_o falling without a pop during reset.

Optional Feature:
HT_RES_BUF_STAT_EN: when defined, the statistics counters and stat_clear_i logic are built as described above. When undefined, the counters are not instantiated, stat_ok_cnt_o and stat_fail_cnt_o are tied to 0, and stat_clear_i is ignored. FIFO behaviour is identical in both builds.

Test Plan:
- Reset, then a single SEARCH result (cmd=1, rescode=0, data=0x1234) with res_ready_i=1 -> res_valid_o high exactly 1 cycle after accept, data 0x1234; stat_ok_cnt[1]=1; used_words back to 0.
- DEPTH=8, res_ready_i=0, push 10 back-to-back results -> 8 accepted; res_ready_o low after the 8th; used_words_o=8; results 9 and 10 are held upstream. Then raise res_ready_i -> all 10 emerge in order, one per cycle after the first.
- Occupancy 1, then push and pop in the same cycle repeatedly for 20 cycles -> used_words_o stays 1, no data lost or reordered, pointers wrap correctly.
- INSERT with rescode 4 (FAIL_MASK bit set) x3 and rescode 2 x2 -> stat_fail_cnt[2]=3, stat_ok_cnt[2]=2; other counters 0.
- CNT_W=4: accept 20 DELETE successes -> stat_ok_cnt[3] saturates at 15. Then assert stat_clear_i in the same cycle as one DELETE accept -> counter=1.
- Assert rst_i low mid-stream with 5 entries buffered -> outputs immediately at reset values, res_ready_o=1; after release, FIFO is empty and the next push works normally.
